// File: rtl/counter_run_controller_pkg.sv
// Shared definitions for the counter run controller: controller state
// encodings, default datapath widths and the controller-to-core command bundle.
// Optional feature macro: CNT_CTRL_PAUSE_EN (enables the PAUSE state).
package counter_run_controller_pkg;

    // Default counter width (q, limit) and loop-count width (loops, loop_cnt).
    localparam int DEF_WIDTH  = 3;
    localparam int DEF_LOOP_W = 4;

    // Binary state encoding. ST_PAUSE is only reachable when CNT_CTRL_PAUSE_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Commands from the controller FSM to the counter core.
    typedef struct packed {
        logic clr;  // synchronous clear of q
        logic en;   // advance q by one, wrapping to 0 at limit
    } core_ctrl_t;

endpackage

// File: rtl/counter_run_controller_core.sv
// Counter core: WIDTH-bit positive-edge up counter with synchronous clear,
// count enable and wrap-to-zero at a programmable limit. at_limit flags that
// the current value equals the limit, so the next enabled edge wraps.
module counter_run_controller_core
    import counter_run_controller_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             at_limit
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: clear wins, otherwise step or wrap when enabled, otherwise hold.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == limit) ? '0 : q_q + 1'b1;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q        = q_q;
    assign at_limit = (q_q == limit);

endmodule

// File: rtl/counter_run_controller.sv
// Counter run controller: sequences the counter core through run sessions.
// A session counts 0..limit and wraps, for a latched number of loops (0 means
// run until stop), then emits a one-cycle done pulse. stop aborts at once.
// Optional feature macro: CNT_CTRL_PAUSE_EN -- when defined, pause=1 in RUN
// freezes the count in a PAUSE state; when undefined the pause port is ignored.
module counter_run_controller
    import counter_run_controller_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOOP_W = DEF_LOOP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [WIDTH-1:0]  limit,
    input  logic [LOOP_W-1:0] loops,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              wrap,
    output logic              done,
    output logic [LOOP_W-1:0] loop_cnt
);

    state_e            state_q,    state_d;
    logic [WIDTH-1:0]  limit_q,    limit_d;
    logic [LOOP_W-1:0] loops_q,    loops_d;
    logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
    logic              busy_q,     busy_d;
    logic              wrap_q,     wrap_d;
    logic              done_q,     done_d;
    logic [LOOP_W-1:0] loop_inc;
    core_ctrl_t        ctrl;
    logic              at_limit;

`ifndef CNT_CTRL_PAUSE_EN
    // Without the pause feature the port exists but drives nothing.
    logic unused_pause;
    assign unused_pause = pause;
`endif

    counter_run_controller_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctrl.clr),
        .en       (ctrl.en),
        .limit    (limit_q),
        .q        (q),
        .at_limit (at_limit)
    );

    // Next-state and next-output logic; priority in an active session is stop, then pause, then counting.
    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        loops_d    = loops_q;
        loop_cnt_d = loop_cnt_q;
        busy_d     = busy_q;
        wrap_d     = 1'b0;
        done_d     = 1'b0;
        ctrl       = '0;
        loop_inc   = loop_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // A simultaneous stop vetoes the start.
                if (start && !stop) begin
                    state_d    = ST_RUN;
                    ctrl.clr   = 1'b1;
                    loop_cnt_d = '0;
                    limit_d    = limit;
                    loops_d    = loops;
                    busy_d     = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    ctrl.clr = 1'b1;
                    busy_d   = 1'b0;
                end
`ifdef CNT_CTRL_PAUSE_EN
                else if (pause) begin
                    state_d = ST_PAUSE;
                end
`endif
                else begin
                    ctrl.en = 1'b1;
                    if (at_limit) begin
                        // The core wraps q to 0 on this edge; this edge closes one loop.
                        wrap_d     = 1'b1;
                        loop_cnt_d = loop_inc;
                        if ((loops_q != '0) && (loop_inc == loops_q)) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

`ifdef CNT_CTRL_PAUSE_EN
            ST_PAUSE: begin
                // Count and loop counter are frozen; release returns to RUN with q held.
                if (stop) begin
                    state_d  = ST_IDLE;
                    ctrl.clr = 1'b1;
                    busy_d   = 1'b0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
`endif

            ST_DONE: begin
                // One-cycle completion state; start is ignored here and loop_cnt is kept.
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                ctrl.clr = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Controller state, latched session parameters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            limit_q    <= '0;
            loops_q    <= '0;
            loop_cnt_q <= '0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            loops_q    <= loops_d;
            loop_cnt_q <= loop_cnt_d;
            busy_q     <= busy_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign loop_cnt = loop_cnt_q;

endmodule

// File: tb/tb_counter_run_controller.sv
// Testbench for counter_run_controller: a table of directed per-cycle vectors
// for a full two-loop session, plus hand-written multi-cycle sequences for the
// corner cases (limit 0, free-run with stop, stop at wrap, loop counter
// rollover, pause, asynchronous reset mid-run).
module tb_counter_run_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] limit = '0;
    logic [3:0] loops = '0;
    logic [2:0] q;
    logic       busy;
    logic       wrap;
    logic       done;
    logic [3:0] loop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic [2:0] limit;
        logic [3:0] loops;
        int         q;
        int         busy;
        int         wrap;
        int         done;
        int         lc;
    } vec_t;

    vec_t vecs[16];

    counter_run_controller #(
        .WIDTH  (3),
        .LOOP_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .limit    (limit),
        .loops    (loops),
        .q        (q),
        .busy     (busy),
        .wrap     (wrap),
        .done     (done),
        .loop_cnt (loop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int eq, input int eb, input int ew,
                              input int ed, input int elc);
        check({tag, ".q"},        32'(q),        eq);
        check({tag, ".busy"},     32'(busy),     eb);
        check({tag, ".wrap"},     32'(wrap),     ew);
        check({tag, ".done"},     32'(done),     ed);
        check({tag, ".loop_cnt"}, 32'(loop_cnt), elc);
    endtask

    // Drive inputs at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic step(input logic s, input logic sp, input logic p,
                        input logic [2:0] l, input logic [3:0] lp);
        @(negedge clk);
        start = s;
        stop  = sp;
        pause = p;
        limit = l;
        loops = lp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Session limit=5 loops=2; from vec1 on, start is held high with limit=2 loops=1
        // to show that start and parameter changes while busy, and start in DONE, are ignored.
        //              st sp p  lim lp   q  b  w  d  lc
        vecs[0]  = '{1, 0, 0, 5, 2,   0, 1, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 2, 1,   1, 1, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 2, 1,   2, 1, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 2, 1,   3, 1, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 2, 1,   4, 1, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 2, 1,   5, 1, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 2, 1,   0, 1, 1, 0, 1};
        vecs[7]  = '{1, 0, 0, 2, 1,   1, 1, 0, 0, 1};
        vecs[8]  = '{1, 0, 0, 2, 1,   2, 1, 0, 0, 1};
        vecs[9]  = '{1, 0, 0, 2, 1,   3, 1, 0, 0, 1};
        vecs[10] = '{1, 0, 0, 2, 1,   4, 1, 0, 0, 1};
        vecs[11] = '{1, 0, 0, 2, 1,   5, 1, 0, 0, 1};
        vecs[12] = '{1, 0, 0, 2, 1,   0, 0, 1, 1, 2};
        vecs[13] = '{1, 0, 0, 2, 1,   0, 0, 0, 0, 2};
        vecs[14] = '{1, 1, 0, 2, 1,   0, 0, 0, 0, 2};
        vecs[15] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 2};

        // Reset values while rst is held low.
        #1;
        check_outs("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].limit, vecs[i].loops);
            check_outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].wrap,
                       vecs[i].done, vecs[i].lc);
        end

        // limit=0, loops=3: q stays 0, wrap on three consecutive cycles, done with the third.
        step(1, 0, 0, 0, 3);
        check_outs("lim0.start", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 0);
            check_outs($sformatf("lim0.c%0d", k), 0, (k < 3) ? 1 : 0, 1, (k == 3) ? 1 : 0, k);
        end
        step(0, 0, 0, 0, 0);
        check_outs("lim0.idle", 0, 0, 0, 0, 3);

        // limit=7, loops=0: free-run through one wrap, stop at q=4, done never asserted.
        done_seen = 0;
        step(1, 0, 0, 7, 0);
        check_outs("free.start", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 0, 0);
            done_seen += int'(done);
            check_outs($sformatf("free.c%0d", k), k % 8, 1, (k == 8) ? 1 : 0, 0, (k >= 8) ? 1 : 0);
        end
        step(0, 1, 0, 0, 0);
        done_seen += int'(done);
        check("free.stop.q", 32'(q), 0);
        check("free.stop.busy", 32'(busy), 0);
        check("free.stop.wrap", 32'(wrap), 0);
        step(0, 0, 0, 0, 0);
        done_seen += int'(done);
        check("free.no_done", 32'(done_seen), 0);

        // Stop on the edge that would wrap and complete: no wrap, no done, no loop counted.
        step(1, 0, 0, 1, 1);
        check_outs("sw.start", 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_outs("sw.at_lim", 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check_outs("sw.stop", 0, 0, 0, 0, 0);

        // loops=0 with limit=0: loop counter rolls over silently after 16 loops.
        done_seen = 0;
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0, 0, 0);
            done_seen += int'(done);
        end
        check_outs("roll", 0, 1, 1, 0, 0);
        check("roll.no_done", 32'(done_seen), 0);
        step(0, 1, 0, 0, 0);
        check("roll.stop.busy", 32'(busy), 0);

        // Pause held for 3 cycles at q=2 on a limit=5 free-run.
        step(1, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_outs("pz.pre", 2, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 1, 0, 0);
`ifdef CNT_CTRL_PAUSE_EN
            check_outs($sformatf("pz.hold%0d", k), 2, 1, 0, 0, 0);
`else
            check_outs($sformatf("pz.ign%0d", k), 2 + k, 1, 0, 0, 0);
`endif
        end
        step(0, 0, 0, 0, 0);
`ifdef CNT_CTRL_PAUSE_EN
        check_outs("pz.rel", 2, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_outs("pz.resume", 3, 1, 0, 0, 0);
`else
        check_outs("pz.wrap", 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        check_outs("pz.next", 1, 1, 0, 0, 1);
`endif
        step(0, 1, 0, 0, 0);
        check("pz.stop.busy", 32'(busy), 0);

        // Asynchronous reset mid-run at q=3 takes effect before the next clock edge.
        step(1, 0, 0, 6, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_outs("rst.pre", 3, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("rst.async", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        check_outs("rst.idle", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
